// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA screen selector.
// Holds the sync polarity default, FSM states and request decode.
package vga_pkg;

    localparam bit SYNC_ACTIVE_DEF = 1'b0;

    typedef enum logic [1:0] {
        SHOW,
        PENDING,
        BLANK
    } state_t;

    // Exactly one bit set gives its index; anything else falls back to 0.
    function automatic int unsigned onehot_to_idx(
        input logic [31:0] v
    );
        int unsigned idx;
        idx = 0;
        if ($countones(v) == 1) begin
            for (int i = 0; i < 32; i++) begin
                if (v[i]) idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_vsync_edge_module.sv
// Registered VSYNC sampler with an active-edge pulse.
// The pulse is high on the cycle the active level is first seen.
module vga_vsync_edge_module #(
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic active_edge
);

    logic vsync_q;

    // Previous VSYNC level; starts inactive so reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_q <= ~SYNC_ACTIVE;
        else        vsync_q <= vsync;
    end

    assign active_edge = (vsync == SYNC_ACTIVE)
                      && (vsync_q != SYNC_ACTIVE);

endmodule

// File: rtl/vga_screen_mux_module.sv
// Frame-synchronous screen source selector for the VGA pins.
// Switches sources only at a VSYNC edge, optionally blanking RGB.
module vga_screen_mux_module
    import vga_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int COLOR_W      = 1,
    parameter int BLANK_FRAMES = 1,
    parameter bit SYNC_ACTIVE  = SYNC_ACTIVE_DEF
) (
    input  logic                         CLK,
    input  logic                         RSTn,
    input  logic [N_SRC-1:0]             src_vsync,
    input  logic [N_SRC-1:0]             src_hsync,
    input  logic [N_SRC*3*COLOR_W-1:0]   src_rgb,
    input  logic [N_SRC-1:0]             sel_onehot,
    output logic                         VSYNC_Sig_out,
    output logic                         HSYNC_Sig_out,
    output logic [COLOR_W-1:0]           VGA_red_out,
    output logic [COLOR_W-1:0]           VGA_green_out,
    output logic [COLOR_W-1:0]           VGA_blue_out,
    output logic [$clog2(N_SRC)-1:0]     cur_sel,
    output logic                         switching
);

    localparam int SEL_W = $clog2(N_SRC);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int CNT_W = (BLANK_FRAMES > 0)
                         ? $clog2(BLANK_FRAMES + 1) : 1;
    localparam logic [CNT_W:0] CNT_END = (CNT_W + 1)'(BLANK_FRAMES);

    state_t            state, state_nx;
    logic [SEL_W-1:0]  cur_q, cur_nx;
    logic [SEL_W-1:0]  tgt_q, tgt_nx;
    logic [SEL_W-1:0]  req;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic [CNT_W:0]    cnt_inc;
    logic              frame_edge;
    logic              vs_sel;
    logic              hs_sel;
    logic [PIX_W-1:0]  rgb_sel;

    // Edge detector watches whichever source currently owns the sync.
    vga_vsync_edge_module #(
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_edge (
        .clk         (CLK),
        .rst_n       (RSTn),
        .vsync       (src_vsync[cur_q]),
        .active_edge (frame_edge)
    );

    // Malformed one-hot requests fall back to the default source.
    always_comb begin
        req = SEL_W'(onehot_to_idx(32'(sel_onehot)));
    end

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    // Next-state: a request only takes effect at a frame edge.
    always_comb begin
        state_nx = state;
        cur_nx   = cur_q;
        tgt_nx   = tgt_q;
        cnt_nx   = cnt_q;
        unique case (state)
            SHOW: begin
                if (req != cur_q) begin
                    state_nx = PENDING;
                    tgt_nx   = req;
                end
            end
            PENDING: begin
                tgt_nx = req;
                if (req == cur_q) begin
                    state_nx = SHOW;
                end else if (frame_edge) begin
                    cur_nx   = tgt_nx;
                    cnt_nx   = '0;
                    state_nx = (BLANK_FRAMES == 0) ? SHOW : BLANK;
                end
            end
            BLANK: begin
                tgt_nx = req;
                if (frame_edge) begin
                    if (req != cur_q) begin
                        cur_nx = req;
                        cnt_nx = '0;
                    end else if (cnt_inc >= CNT_END) begin
                        cnt_nx   = CNT_END[CNT_W-1:0];
                        state_nx = SHOW;
                    end else begin
                        cnt_nx = cnt_inc[CNT_W-1:0];
                    end
                end
            end
            default: state_nx = SHOW;
        endcase
    end

    // Mux follows the next source so the switch lands on the edge cycle.
    always_comb begin
        vs_sel  = src_vsync[cur_nx];
        hs_sel  = src_hsync[cur_nx];
        rgb_sel = src_rgb[cur_nx*PIX_W +: PIX_W];
        if (state_nx == BLANK) rgb_sel = '0;
    end

    // State, frame counter and the single output register stage.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= SHOW;
            cur_q         <= '0;
            tgt_q         <= '0;
            cnt_q         <= '0;
            VSYNC_Sig_out <= ~SYNC_ACTIVE;
            HSYNC_Sig_out <= ~SYNC_ACTIVE;
            VGA_red_out   <= '0;
            VGA_green_out <= '0;
            VGA_blue_out  <= '0;
        end else begin
            state         <= state_nx;
            cur_q         <= cur_nx;
            tgt_q         <= tgt_nx;
            cnt_q         <= cnt_nx;
            VSYNC_Sig_out <= vs_sel;
            HSYNC_Sig_out <= hs_sel;
            VGA_red_out   <= rgb_sel[PIX_W-1 -: COLOR_W];
            VGA_green_out <= rgb_sel[2*COLOR_W-1 -: COLOR_W];
            VGA_blue_out  <= rgb_sel[COLOR_W-1:0];
        end
    end

    assign cur_sel   = cur_q;
    assign switching = (state != SHOW);

endmodule

// File: tb/tb_vga_screen_mux_module.sv
// Bench for vga_screen_mux_module: reference model plus pinned cases.
// Drives a shrunken shared sync generator with random pixel data.
module tb_vga_screen_mux_module;

    localparam int HT  = 16;
    localparam int VT  = 10;
    localparam int VS0 = 8;
    localparam int SHOWM = 0;
    localparam int PEND  = 1;
    localparam int BLK   = 2;

    typedef struct {
        int         cur;
        int         mode;
        int         left;
        logic       pv;
        logic       ev;
        logic       eh;
        logic [2:0] ergb;
    } mdl_t;

    logic        CLK;
    logic        RSTn;
    logic [3:0]  src_vsync;
    logic [3:0]  src_hsync;
    logic [11:0] src_rgb;
    logic [3:0]  sel_onehot;

    logic       vs1, hs1, r1, g1, b1, sw1;
    logic [1:0] cs1;
    logic       vs0, hs0, r0, g0, b0, sw0;
    logic [1:0] cs0;

    int   errs;
    int   checks;
    int   hc;
    int   vc;
    bit   run_chk;
    mdl_t m1;
    mdl_t m0;

    vga_screen_mux_module #(
        .N_SRC(4), .COLOR_W(1), .BLANK_FRAMES(1), .SYNC_ACTIVE(1'b0)
    ) u_dut (
        .CLK(CLK), .RSTn(RSTn),
        .src_vsync(src_vsync), .src_hsync(src_hsync),
        .src_rgb(src_rgb), .sel_onehot(sel_onehot),
        .VSYNC_Sig_out(vs1), .HSYNC_Sig_out(hs1),
        .VGA_red_out(r1), .VGA_green_out(g1), .VGA_blue_out(b1),
        .cur_sel(cs1), .switching(sw1)
    );

    vga_screen_mux_module #(
        .N_SRC(4), .COLOR_W(1), .BLANK_FRAMES(0), .SYNC_ACTIVE(1'b0)
    ) u_dut0 (
        .CLK(CLK), .RSTn(RSTn),
        .src_vsync(src_vsync), .src_hsync(src_hsync),
        .src_rgb(src_rgb), .sel_onehot(sel_onehot),
        .VSYNC_Sig_out(vs0), .HSYNC_Sig_out(hs0),
        .VGA_red_out(r0), .VGA_green_out(g0), .VGA_blue_out(b0),
        .cur_sel(cs0), .switching(sw0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic mdl_t mreset();
        mdl_t s;
        s.cur  = 0;
        s.mode = SHOWM;
        s.left = 0;
        s.pv   = 1'b1;
        s.ev   = 1'b1;
        s.eh   = 1'b1;
        s.ergb = 3'b000;
        return s;
    endfunction

    // One pixel clock of the screen selector, from its stated rules.
    function automatic mdl_t step(
        input mdl_t        s,
        input int          bf,
        input logic [3:0]  sel,
        input logic [3:0]  vs,
        input logic [3:0]  hs,
        input logic [11:0] rgb
    );
        int   req;
        logic fe;
        req  = ($countones(sel) == 1) ? $clog2(sel) : 0;
        fe   = (vs[s.cur] == 1'b0) && (s.pv == 1'b1);
        s.pv = vs[s.cur];
        if (s.mode == SHOWM) begin
            if (req != s.cur) s.mode = PEND;
        end else if (s.mode == PEND) begin
            if (req == s.cur) begin
                s.mode = SHOWM;
            end else if (fe) begin
                s.cur  = req;
                s.left = bf;
                s.mode = (bf == 0) ? SHOWM : BLK;
            end
        end else if (fe) begin
            if (req != s.cur) begin
                s.cur  = req;
                s.left = bf;
            end else begin
                s.left = s.left - 1;
                if (s.left <= 0) s.mode = SHOWM;
            end
        end
        s.ev   = vs[s.cur];
        s.eh   = hs[s.cur];
        s.ergb = (s.mode == BLK) ? 3'b000 : rgb[s.cur*3 +: 3];
        return s;
    endfunction

    task automatic chk(
        input string      nm,
        input logic [7:0] act,
        input logic [7:0] exp
    );
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            m1 <= mreset();
            m0 <= mreset();
        end else begin
            m1 <= step(m1, 1, sel_onehot, src_vsync,
                       src_hsync, src_rgb);
            m0 <= step(m0, 0, sel_onehot, src_vsync,
                       src_hsync, src_rgb);
        end
    end

    always @(negedge CLK) begin
        if (run_chk) begin
            chk("vsync1", 8'(vs1), 8'(m1.ev));
            chk("hsync1", 8'(hs1), 8'(m1.eh));
            chk("rgb1", 8'({r1, g1, b1}), 8'(m1.ergb));
            chk("cur1", 8'(cs1), 8'(m1.cur));
            chk("sw1", 8'(sw1), 8'(m1.mode != SHOWM));
            chk("vsync0", 8'(vs0), 8'(m0.ev));
            chk("hsync0", 8'(hs0), 8'(m0.eh));
            chk("rgb0", 8'({r0, g0, b0}), 8'(m0.ergb));
            chk("cur0", 8'(cs0), 8'(m0.cur));
            chk("sw0", 8'(sw0), 8'(m0.mode != SHOWM));
        end
    end

    task automatic tick();
        @(negedge CLK);
        hc = hc + 1;
        if (hc == HT) begin
            hc = 0;
            vc = (vc + 1) % VT;
        end
        src_vsync = (vc >= VS0) ? 4'b0000 : 4'b1111;
        for (int i = 0; i < 4; i++) begin
            src_hsync[i] = !(hc >= 10 + i && hc < 13 + i);
        end
        src_rgb = 12'($urandom);
    endtask

    task automatic wait_fall();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            logic p;
            p = src_vsync[0];
            tick();
            if (p && !src_vsync[0]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errs++;
            $display("FAIL vsync_wait got=none want=fall");
        end
    endtask

    task automatic pin1(
        input string      nm,
        input logic [1:0] cs,
        input logic       sw,
        input logic [2:0] rgb
    );
        chk({nm, "_cur"}, 8'(cs1), 8'(cs));
        chk({nm, "_sw"}, 8'(sw1), 8'(sw));
        chk({nm, "_rgb"}, 8'({r1, g1, b1}), 8'(rgb));
    endtask

    initial begin
        logic [2:0] sv;
        bit         in_rst;
        errs       = 0;
        checks     = 0;
        hc         = 0;
        vc         = 0;
        run_chk    = 1'b0;
        RSTn       = 1'b0;
        sel_onehot = 4'b0001;
        src_vsync  = 4'b1111;
        src_hsync  = 4'b1111;
        src_rgb    = '0;

        repeat (5) tick();
        run_chk = 1'b1;
        chk("rst_vsync", 8'(vs1), 8'd1);
        chk("rst_hsync", 8'(hs1), 8'd1);
        pin1("rst", 2'd0, 1'b0, 3'b000);

        tick();
        RSTn = 1'b1;
        sv   = src_rgb[2:0];
        @(posedge CLK); #1;
        pin1("release", 2'd0, 1'b0, sv);

        for (int k = 0; k < 400 && vc != 3; k++) tick();
        sel_onehot = 4'b0100;
        @(posedge CLK); #1;
        chk("req_cur", 8'(cs1), 8'd0);
        chk("req_sw", 8'(sw1), 8'd1);
        wait_fall();
        sv = src_rgb[8:6];
        @(posedge CLK); #1;
        pin1("edge1", 2'd2, 1'b1, 3'b000);
        chk("nb_cur", 8'(cs0), 8'd2);
        chk("nb_sw", 8'(sw0), 8'd0);
        chk("nb_rgb", 8'({r0, g0, b0}), 8'(sv));
        wait_fall();
        sv = src_rgb[8:6];
        @(posedge CLK); #1;
        pin1("edge2", 2'd2, 1'b0, sv);

        sel_onehot = 4'b0110;
        wait_fall();
        @(posedge CLK); #1;
        pin1("multi", 2'd0, 1'b1, 3'b000);
        wait_fall();

        repeat (20) tick();
        sel_onehot = 4'b0010;
        repeat (3) tick();
        sel_onehot = 4'b0001;
        repeat (3) tick();
        chk("cancel_cur", 8'(cs1), 8'd0);
        chk("cancel_sw", 8'(sw1), 8'd0);

        sel_onehot = 4'b0100;
        wait_fall();
        repeat (30) tick();
        sel_onehot = 4'b1000;
        wait_fall();
        @(posedge CLK); #1;
        pin1("reblank", 2'd3, 1'b1, 3'b000);
        wait_fall();
        sv = src_rgb[11:9];
        @(posedge CLK); #1;
        pin1("src3", 2'd3, 1'b0, sv);

        sel_onehot = 4'b0001;
        wait_fall();
        repeat (5) tick();
        #2 RSTn = 1'b0;
        #1;
        chk("arst_vsync", 8'(vs1), 8'd1);
        pin1("arst", 2'd0, 1'b0, 3'b000);
        tick();
        RSTn = 1'b1;

        in_rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            if (in_rst) begin
                RSTn   = 1'b1;
                in_rst = 1'b0;
            end
            if ($urandom_range(0, 79) == 0) begin
                case ($urandom_range(0, 3))
                    0, 3:    sel_onehot = 4'(1 << $urandom_range(0, 3));
                    1:       sel_onehot = 4'b0000;
                    default: sel_onehot = 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 999) == 0) begin
                #2 RSTn = 1'b0;
                in_rst = 1'b1;
                #1;
                pin1("rnd_arst", 2'd0, 1'b0, 3'b000);
            end
        end
        RSTn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
